// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// instruction word layout and the default opcode limit.
package imem_loader_pkg;

  localparam int INSTR_W         = 32;
  localparam int OPCODE_MSB      = 31;
  localparam int OPCODE_LSB      = 26;
  localparam int OPCODE_W        = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int IMEM_MAX_OPCODE = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Extract the opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// The slave side is the loader; the master side feeds bytes and observes writes.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5
);

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit instruction word.
// o_word_valid flags, in the cycle the 4th byte is accepted, that o_word
// holds the complete word (including that byte), so the parent can register
// the write for the very next cycle.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [7:0]         i_byte,
  output logic               o_word_valid,
  output logic [INSTR_W-1:0] o_word
);

  logic [1:0]         r_idx;
  logic [INSTR_W-1:0] r_asm;
  logic [4:0]         w_lane;

  assign w_lane       = {r_idx, 3'b000};
  assign o_word_valid = i_accept && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_asm[23:0]};

  // Store each accepted byte in its lane; index wraps so the next byte starts a new word.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx <= 2'd0;
      r_asm <= '0;
    end else if (i_accept) begin
      r_asm[w_lane +: 8] <= i_byte;
      r_idx              <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: reads a word count header followed
// by little-endian words from a byte stream, validates opcodes, writes the
// words to instruction memory and holds the CPU until loading finishes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int MAX_OPCODE = IMEM_MAX_OPCODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  imem_loader_if.slave    io_bus,
  output logic            o_cpu_hold,
  output logic [ADDR_W:0] o_words_loaded,
  output logic            o_done,
  output logic            o_err
);

  localparam logic [8:0]          DEPTH_9 = 9'(DEPTH);
  localparam logic [OPCODE_W-1:0] MAX_OP  = OPCODE_W'(MAX_OPCODE);

  state_t             r_state;
  state_t             w_next;

  logic               r_byte_ready;
  logic               r_imem_we;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [INSTR_W-1:0] r_imem_wdata;
  logic               r_cpu_hold;
  logic [ADDR_W:0]    r_words_loaded;
  logic [ADDR_W:0]    r_word_count;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_start_ok;
  logic               w_asm_accept;
  logic               w_word_valid;
  logic [INSTR_W-1:0] w_word;
  logic               w_op_bad;
  logic               w_hdr_bad;
  logic               w_write;
  logic [ADDR_W:0]    w_wl_inc;

  // byte_ready is registered and tracks HDR/LOAD exactly, so it doubles as the accept qualifier.
  assign w_accept     = io_bus.byte_valid && r_byte_ready;
  assign w_start_ok   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_asm_accept = w_accept && (r_state == ST_LOAD);
  assign w_hdr_bad    = (io_bus.byte_in == 8'd0) || ({1'b0, io_bus.byte_in} > DEPTH_9);
  assign w_op_bad     = opcode_of(w_word) > MAX_OP;
  assign w_write      = w_word_valid && !w_op_bad;
  assign w_wl_inc     = r_words_loaded + (ADDR_W + 1)'(1);

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_accept     (w_asm_accept),
    .i_byte       (io_bus.byte_in),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: header validation, opcode check and completion.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) w_next = ST_HDR;
      end
      ST_HDR: begin
        if (w_accept) w_next = w_hdr_bad ? ST_ERR : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_word_valid) begin
          if (w_op_bad)                        w_next = ST_ERR;
          else if (w_wl_inc == r_word_count)   w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered outputs, derived from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_ready   <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_cpu_hold     <= 1'b0;
      r_words_loaded <= '0;
      r_word_count   <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_byte_ready <= (w_next == ST_HDR) || (w_next == ST_LOAD);
      r_cpu_hold   <= (w_next == ST_HDR) || (w_next == ST_LOAD) || (w_next == ST_ERR);
      r_done       <= (w_next == ST_DONE);
      r_err        <= (w_next == ST_ERR);
      r_imem_we    <= w_write;
      if (w_write) begin
        r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
        r_imem_wdata   <= w_word;
        r_words_loaded <= w_wl_inc;
      end
      if (w_start_ok) begin
        r_words_loaded <= '0;
        r_word_count   <= '0;
      end else if ((r_state == ST_HDR) && w_accept && !w_hdr_bad) begin
        r_word_count <= (ADDR_W + 1)'(io_bus.byte_in);
      end
    end
  end

  assign io_bus.byte_ready = r_byte_ready;
  assign io_bus.imem_we    = r_imem_we;
  assign io_bus.imem_addr  = r_imem_addr;
  assign io_bus.imem_wdata = r_imem_wdata;
  assign o_cpu_hold        = r_cpu_hold;
  assign o_words_loaded    = r_words_loaded;
  assign o_done            = r_done;
  assign o_err             = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven load sessions with a
// write scoreboard, plus hand-written reset and start-ignore sequences.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic       o_cpu_hold;
  logic [5:0] o_words_loaded;
  logic       o_done;
  logic       o_err;

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.DEPTH(32), .ADDR_W(5), .MAX_OPCODE(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .io_bus         (bus),
    .o_cpu_hold     (o_cpu_hold),
    .o_words_loaded (o_words_loaded),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [7:0]  hdr;
    int          nsend;
    logic [31:0] base;
    logic [31:0] step;
    bit          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_wl;
    bit          exp_hold;
  } vec_t;

  wr_t  q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 64'({bus.imem_addr, bus.imem_wdata}), 64'(0));
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("write_addr_data", 64'({bus.imem_addr, bus.imem_wdata}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    idle(1);
    i_start = 1'b0;
  endtask

  // Offer one byte and wait (bounded) for the handshake; optional idle cycle before it.
  task automatic send_byte(input logic [7:0] b, input bit gap, output int stalls);
    bit got;
    stalls = 0;
    got    = 1'b0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      idle(1);
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bus.byte_ready === 1'b1) got = 1'b1;
      else stalls++;
      idle(1);
    end
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int          stalls;
    int          st;
    bit          bad;
    bit          hdr_ok;
    logic [31:0] w;
    logic [7:0]  b;
    stalls = 0;
    bad    = 1'b0;
    pulse_start();
    chk({v.name, "_rdy_hdr"},  64'(bus.byte_ready), 64'(1));
    chk({v.name, "_hold_hdr"}, 64'(o_cpu_hold),     64'(1));
    send_byte(v.hdr, v.gap, st);
    stalls += st;
    hdr_ok = (v.hdr != 8'd0) && (v.hdr <= 8'd32);
    if (hdr_ok) begin
      for (int i = 0; i < v.nsend && !bad; i++) begin
        w = v.base + v.step * 32'(i);
        for (int k = 0; k < 4; k++) begin
          b = w[8*k +: 8];
          if (k == 3) begin
            if (w[31:26] > 6'd16) bad = 1'b1;
            else q.push_back('{addr: 5'(i), data: w});
          end
          send_byte(b, v.gap, st);
          stalls += st;
        end
        chk({v.name, "_we_after_word"}, 64'(bus.imem_we), 64'(!bad));
      end
    end
    bus.byte_valid = 1'b0;
    if (!v.gap && v.exp_done) chk({v.name, "_no_stall"}, 64'(stalls), 64'(0));
    idle(2);
    chk({v.name, "_done"}, 64'(o_done),         64'(v.exp_done));
    chk({v.name, "_err"},  64'(o_err),          64'(v.exp_err));
    chk({v.name, "_wl"},   64'(o_words_loaded), 64'(v.exp_wl));
    chk({v.name, "_hold"}, 64'(o_cpu_hold),     64'(v.exp_hold));
    chk({v.name, "_rdy"},  64'(bus.byte_ready), 64'(0));
    // Bytes offered while finished must be ignored.
    bus.byte_in    = 8'hFF;
    bus.byte_valid = 1'b1;
    idle(3);
    bus.byte_valid = 1'b0;
    chk({v.name, "_ign_state"}, 64'({o_done, o_err, o_words_loaded}),
        64'({v.exp_done, v.exp_err, 6'(v.exp_wl)}));
  endtask

  initial begin
    int st;
    vecs[0] = '{"basic2", 8'h02, 2,  32'h04000001, 32'h04000009, 1'b0, 1'b1, 1'b0, 2,  1'b0};
    vecs[1] = '{"hdr0",   8'h00, 0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0,  1'b1};
    vecs[2] = '{"one0",   8'h01, 1,  32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1,  1'b0};
    vecs[3] = '{"hdr33",  8'h21, 0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0,  1'b1};
    vecs[4] = '{"badop",  8'h01, 1,  32'h44000000, 32'h0,        1'b0, 1'b0, 1'b1, 0,  1'b1};
    vecs[5] = '{"gap3",   8'h03, 3,  32'h00000011, 32'h20000000, 1'b1, 1'b1, 1'b0, 3,  1'b0};
    vecs[6] = '{"hdr32",  8'h20, 32, 32'h00000100, 32'h00010003, 1'b0, 1'b1, 1'b0, 32, 1'b0};
    vecs[7] = '{"midbad", 8'h03, 2,  32'h10000000, 32'h34000000, 1'b0, 1'b0, 1'b1, 1,  1'b1};

    // Reset with start and a byte pending: reset must win.
    rst            = 1'b1;
    i_start        = 1'b1;
    bus.byte_in    = 8'h02;
    bus.byte_valid = 1'b1;
    idle(3);
    rst            = 1'b0;
    i_start        = 1'b0;
    bus.byte_valid = 1'b0;
    chk("rst_ready", 64'(bus.byte_ready), 64'(0));
    chk("rst_we",    64'(bus.imem_we),    64'(0));
    chk("rst_addr",  64'(bus.imem_addr),  64'(0));
    chk("rst_wdata", 64'(bus.imem_wdata), 64'(0));
    chk("rst_ctrl",  64'({o_cpu_hold, o_words_loaded, o_done, o_err}), 64'(0));
    bus.byte_valid = 1'b1;
    idle(2);
    bus.byte_valid = 1'b0;
    chk("idle_ignores_bytes", 64'({bus.byte_ready, o_cpu_hold, o_done, o_err}), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset after the 2nd byte of the first word abandons it without a write.
    pulse_start();
    send_byte(8'h02, 1'b0, st);
    send_byte(8'h11, 1'b0, st);
    send_byte(8'h22, 1'b0, st);
    bus.byte_in = 8'h33;
    rst         = 1'b1;
    idle(1);
    rst            = 1'b0;
    bus.byte_valid = 1'b0;
    chk("midrst_we",   64'(bus.imem_we), 64'(0));
    chk("midrst_ctrl", 64'({bus.byte_ready, o_cpu_hold, o_words_loaded, o_done, o_err}), 64'(0));
    idle(1);
    chk("midrst_we_next", 64'(bus.imem_we), 64'(0));
    pulse_start();
    send_byte(8'h01, 1'b0, st);
    q.push_back('{addr: 5'd0, data: 32'h0C0000AB});
    send_byte(8'hAB, 1'b0, st);
    send_byte(8'h00, 1'b0, st);
    send_byte(8'h00, 1'b0, st);
    send_byte(8'h0C, 1'b0, st);
    chk("midrst_reload_we", 64'(bus.imem_we), 64'(1));
    bus.byte_valid = 1'b0;
    idle(2);
    chk("midrst_reload_done", 64'({o_done, o_words_loaded}), 64'({1'b1, 6'd1}));

    // Start pulses during HDR and mid-word are ignored.
    pulse_start();
    pulse_start();
    send_byte(8'h02, 1'b0, st);
    q.push_back('{addr: 5'd0, data: 32'h05060708});
    send_byte(8'h08, 1'b0, st);
    send_byte(8'h07, 1'b0, st);
    i_start = 1'b1;
    send_byte(8'h06, 1'b0, st);
    i_start = 1'b0;
    send_byte(8'h05, 1'b0, st);
    chk("startign_we0", 64'({bus.imem_we, o_words_loaded}), 64'({1'b1, 6'd1}));
    q.push_back('{addr: 5'd1, data: 32'h0A0B0C0D});
    send_byte(8'h0D, 1'b0, st);
    send_byte(8'h0C, 1'b0, st);
    send_byte(8'h0B, 1'b0, st);
    send_byte(8'h0A, 1'b0, st);
    chk("startign_we1", 64'(bus.imem_we), 64'(1));
    bus.byte_valid = 1'b0;
    idle(2);
    chk("startign_done", 64'({o_done, o_err, o_cpu_hold, o_words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 6'd2}));

    idle(2);
    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
